hssl_link_handshake: RTL and testbench

//  Link bring-up and framing stage between the user datapath and hssl_transceiver.
//  - Drives the GT tx word and consumes the GT rx word.
//  - Runs a handshake with the SpiNNaker end of the HSSL.
//  - Produces handshake_complete for the transceiver's stalled-link reset watchdog.
//  - Once linked, passes user words in both directions and strips K-character fill.
//  - System integration ties GT tx_usrclk2 and rx_usrclk2 to one clock, so this block runs on clk_in.

---
 rtl/hssl_link_handshake_pkg.sv | 30 +++
 rtl/hssl_link_handshake_if.sv | 28 ++
 rtl/hssl_link_handshake_err_monitor.sv | 48 ++++
 rtl/hssl_link_handshake.sv | 126 ++++++++++++
 tb/tb_hssl_link_handshake.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hssl_link_handshake_pkg.sv
// Shared constants for the HSSL link handshake: K-char fields, control words, FSM encoding.
package hssl_link_handshake_pkg;

    localparam logic [7:0]  K28_5        = 8'hBC;
    localparam logic [3:0]  CHARISK_K0   = 4'b0001;
    localparam logic [3:0]  CHARISK_DATA = 4'b0000;
    localparam logic [15:0] HS_TAG       = 16'h4853;
    localparam logic [15:0] ACK_TAG      = 16'h414B;
    localparam logic [31:0] IDLE_W       = {24'h00_0000, K28_5};

    typedef enum logic [1:0] {
        ST_WAIT_GT  = 2'd0,
        ST_SEND_HS  = 2'd1,
        ST_SEND_ACK = 2'd2,
        ST_LINKED   = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  charisk;
    } gt_word_t;

    function automatic gt_word_t ctrl_word(input logic [15:0] tag, input logic [7:0] ver);
        gt_word_t w;
        w.data    = {tag, ver, K28_5};
        w.charisk = CHARISK_K0;
        return w;
    endfunction

endpackage

// File: rtl/hssl_link_handshake_if.sv
// GT word path and user word path of the link stage; master is the link block.
interface hssl_link_handshake_if;
    logic [31:0] gt_tx_data_out;
    logic [3:0]  gt_tx_charisk_out;
    logic [31:0] gt_rx_data_in;
    logic [3:0]  gt_rx_charisk_in;
    logic [3:0]  gt_rx_disperr_in;
    logic [3:0]  gt_rx_encerr_in;
    logic [31:0] usr_tx_data_in;
    logic        usr_tx_vld_in;
    logic        usr_tx_rdy_out;
    logic [31:0] usr_rx_data_out;
    logic        usr_rx_vld_out;

    modport master (
        output gt_tx_data_out, gt_tx_charisk_out,
        input  gt_rx_data_in, gt_rx_charisk_in, gt_rx_disperr_in, gt_rx_encerr_in,
        input  usr_tx_data_in, usr_tx_vld_in,
        output usr_tx_rdy_out, usr_rx_data_out, usr_rx_vld_out
    );

    modport slave (
        input  gt_tx_data_out, gt_tx_charisk_out,
        output gt_rx_data_in, gt_rx_charisk_in, gt_rx_disperr_in, gt_rx_encerr_in,
        output usr_tx_data_in, usr_tx_vld_in,
        input  usr_tx_rdy_out, usr_rx_data_out, usr_rx_vld_out
    );
endinterface

// File: rtl/hssl_link_handshake_err_monitor.sv
// Rx error monitor: windowed bad-word count with trip, plus saturating lifetime total.
module hssl_link_handshake_err_monitor #(
    parameter int ERR_WIN   = 256,
    parameter int ERR_LIMIT = 8
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        active_in,
    input  logic        bad_in,
    output logic        trip_out,
    output logic [15:0] err_cnt_out
);
    localparam int WIN_W = $clog2(ERR_WIN);
    localparam int CNT_W = $clog2(ERR_LIMIT + 1);

    logic [WIN_W-1:0] win_cyc_q, win_cyc_d;
    logic [CNT_W-1:0] win_err_q, win_err_d, win_base, win_next;
    logic [15:0]      tot_q, tot_d;

    always_comb begin
        // Window position 0 starts a fresh count, including that cycle's word.
        win_base  = (win_cyc_q == '0) ? '0 : win_err_q;
        win_next  = win_base + CNT_W'(bad_in);
        trip_out  = active_in && bad_in && (win_next == CNT_W'(ERR_LIMIT));
        win_cyc_d = '0;
        win_err_d = '0;
        tot_d     = tot_q;
        if (active_in) begin
            win_cyc_d = (win_cyc_q == WIN_W'(ERR_WIN - 1)) ? '0 : win_cyc_q + WIN_W'(1);
            win_err_d = trip_out ? '0 : win_next;
            if (bad_in && tot_q != 16'hFFFF) tot_d = tot_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            win_cyc_q <= '0;
            win_err_q <= '0;
            tot_q     <= '0;
        end else begin
            win_cyc_q <= win_cyc_d;
            win_err_q <= win_err_d;
            tot_q     <= tot_d;
        end
    end

    assign err_cnt_out = tot_q;
endmodule

// File: rtl/hssl_link_handshake.sv
// HSSL link bring-up: HS/ACK handshake with the peer, then user word pass-through with K fill stripped.
module hssl_link_handshake
    import hssl_link_handshake_pkg::*;
#(
    parameter logic [7:0] HS_VERSION   = 8'h01,
    parameter int         HS_MATCH_CNT = 16,
    parameter int         HS_TIMEOUT   = 1024,
    parameter int         ERR_WIN      = 256,
    parameter int         ERR_LIMIT    = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  gt_tx_reset_done_in,
    input  logic                  gt_rx_reset_done_in,
    hssl_link_handshake_if.master lnk,
    output logic                  handshake_complete_out,
    output logic                  version_mismatch_out,
    output logic [15:0]           rx_err_cnt_out
);
    localparam int       MATCH_W   = $clog2(HS_MATCH_CNT + 1);
    localparam int       TO_W      = $clog2(HS_TIMEOUT + 1);
    localparam gt_word_t IDLE_WORD = '{data: IDLE_W, charisk: CHARISK_K0};
    localparam gt_word_t HS_WORD   = ctrl_word(HS_TAG, HS_VERSION);
    localparam gt_word_t ACK_WORD  = ctrl_word(ACK_TAG, HS_VERSION);

    state_e             state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic [TO_W-1:0]    to_q, to_d, to_inc;
    gt_word_t           tx_q, tx_d;
    logic [31:0]        rxd_q, rxd_d;
    logic               mis_q, mis_d, rdy_q, rdy_d, hc_q, hc_d, rxv_q, rxv_d;
    logic               gt_ok, rx_good, rx_k0, rx_hs, rx_hs_badver, rx_ack, rx_data, trip;

    always_comb begin
        gt_ok        = gt_tx_reset_done_in && gt_rx_reset_done_in;
        rx_good      = (lnk.gt_rx_disperr_in == 4'b0) && (lnk.gt_rx_encerr_in == 4'b0);
        rx_k0        = rx_good && (lnk.gt_rx_charisk_in == CHARISK_K0);
        rx_hs        = rx_k0 && (lnk.gt_rx_data_in == HS_WORD.data);
        rx_ack       = rx_k0 && (lnk.gt_rx_data_in == ACK_WORD.data);
        rx_hs_badver = rx_k0 && (lnk.gt_rx_data_in[31:16] == HS_TAG)
                       && (lnk.gt_rx_data_in[7:0] == K28_5)
                       && (lnk.gt_rx_data_in[15:8] != HS_VERSION);
        rx_data      = rx_good && (lnk.gt_rx_charisk_in == CHARISK_DATA);
    end

    hssl_link_handshake_err_monitor #(
        .ERR_WIN   (ERR_WIN),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_err_mon (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .active_in   (state_q != ST_WAIT_GT),
        .bad_in      (!rx_good),
        .trip_out    (trip),
        .err_cnt_out (rx_err_cnt_out)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_WAIT_GT;
            match_q <= '0;
            to_q    <= '0;
            tx_q    <= IDLE_WORD;
            rxd_q   <= '0;
            mis_q   <= 1'b0;
            rdy_q   <= 1'b0;
            hc_q    <= 1'b0;
            rxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            to_q    <= to_d;
            tx_q    <= tx_d;
            rxd_q   <= rxd_d;
            mis_q   <= mis_d;
            rdy_q   <= rdy_d;
            hc_q    <= hc_d;
            rxv_q   <= rxv_d;
        end
    end

    always_comb begin
        match_inc = match_q + MATCH_W'(1);
        to_inc    = to_q + TO_W'(1);
        state_d   = state_q;
        if (!gt_ok) begin
            state_d = ST_WAIT_GT;
        end else begin
            case (state_q)
                ST_WAIT_GT:  state_d = ST_SEND_HS;
                ST_SEND_HS:  if (rx_hs && match_inc == MATCH_W'(HS_MATCH_CNT)) state_d = ST_SEND_ACK;
                ST_SEND_ACK: begin
                    if (rx_ack || rx_data)                 state_d = ST_LINKED;
                    else if (to_inc == TO_W'(HS_TIMEOUT)) state_d = ST_SEND_HS;
                end
                ST_LINKED:   if (rx_hs || trip) state_d = ST_SEND_HS;
                default:     state_d = ST_WAIT_GT;
            endcase
        end
    end

    always_comb begin
        match_d = (state_q == ST_SEND_HS && state_d == ST_SEND_HS && rx_hs) ? match_inc : '0;
        to_d    = (state_q == ST_SEND_ACK && state_d == ST_SEND_ACK) ? to_inc : '0;
        mis_d   = mis_q || (gt_ok && state_q == ST_SEND_HS && rx_hs_badver);
        rdy_d   = (state_d == ST_LINKED);
        hc_d    = (state_d == ST_LINKED);
        rxv_d   = (state_q == ST_LINKED) && (state_d == ST_LINKED) && rx_data;
        rxd_d   = rxv_d ? lnk.gt_rx_data_in : rxd_q;
        case (state_d)
            ST_SEND_HS:  tx_d = HS_WORD;
            ST_SEND_ACK: tx_d = ACK_WORD;
            default:     tx_d = IDLE_WORD;
        endcase
        // A word accepted in the final LINKED cycle still goes out ahead of the control word.
        if (lnk.usr_tx_vld_in && rdy_q) tx_d = '{data: lnk.usr_tx_data_in, charisk: CHARISK_DATA};
    end

    assign lnk.gt_tx_data_out      = tx_q.data;
    assign lnk.gt_tx_charisk_out   = tx_q.charisk;
    assign lnk.usr_tx_rdy_out      = rdy_q;
    assign lnk.usr_rx_data_out     = rxd_q;
    assign lnk.usr_rx_vld_out      = rxv_q;
    assign handshake_complete_out  = hc_q;
    assign version_mismatch_out    = mis_q;
endmodule

// File: tb/tb_hssl_link_handshake.sv
// Random + directed bench for hssl_link_handshake against a rule-level link model, plus a loopback pair.
module tb_hssl_link_handshake;
    localparam logic [31:0] IDLE_LIT = 32'h0000_00BC;
    localparam logic [31:0] HS_LIT   = 32'h4853_01BC;
    localparam logic [31:0] HS_BADV  = 32'h4853_02BC;
    localparam logic [31:0] ACK_LIT  = 32'h414B_01BC;
    localparam int HS_N = 16, TO_N = 1024, WIN_N = 256, LIM_N = 8;
    localparam int S_WAIT = 0, S_HS = 1, S_ACK = 2, S_LINK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, txdn, rxdn, hc, mis;
    logic [15:0] ec;
    hssl_link_handshake_if lnk_if();
    hssl_link_handshake dut (
        .clk_in(clk), .reset_in(rst), .gt_tx_reset_done_in(txdn), .gt_rx_reset_done_in(rxdn),
        .lnk(lnk_if), .handshake_complete_out(hc), .version_mismatch_out(mis), .rx_err_cnt_out(ec)
    );

    logic lb_rst, lb_hc_a, lb_hc_b, lb_mis_a, lb_mis_b;
    logic [15:0] lb_ec_a, lb_ec_b;
    hssl_link_handshake_if lb_a();
    hssl_link_handshake_if lb_b();
    assign lb_a.gt_rx_data_in    = lb_b.gt_tx_data_out;
    assign lb_a.gt_rx_charisk_in = lb_b.gt_tx_charisk_out;
    assign lb_b.gt_rx_data_in    = lb_a.gt_tx_data_out;
    assign lb_b.gt_rx_charisk_in = lb_a.gt_tx_charisk_out;
    assign lb_a.gt_rx_disperr_in = 4'b0;
    assign lb_a.gt_rx_encerr_in  = 4'b0;
    assign lb_b.gt_rx_disperr_in = 4'b0;
    assign lb_b.gt_rx_encerr_in  = 4'b0;
    assign lb_a.usr_tx_data_in   = 32'h0;
    assign lb_a.usr_tx_vld_in    = 1'b0;
    assign lb_b.usr_tx_data_in   = 32'h0;
    assign lb_b.usr_tx_vld_in    = 1'b0;
    hssl_link_handshake lb_dut_a (
        .clk_in(clk), .reset_in(lb_rst), .gt_tx_reset_done_in(1'b1), .gt_rx_reset_done_in(1'b1),
        .lnk(lb_a), .handshake_complete_out(lb_hc_a), .version_mismatch_out(lb_mis_a), .rx_err_cnt_out(lb_ec_a)
    );
    hssl_link_handshake lb_dut_b (
        .clk_in(clk), .reset_in(lb_rst), .gt_tx_reset_done_in(1'b1), .gt_rx_reset_done_in(1'b1),
        .lnk(lb_b), .handshake_complete_out(lb_hc_b), .version_mismatch_out(lb_mis_b), .rx_err_cnt_out(lb_ec_b)
    );

    int n_total = 0, n_bad = 0, n_print = 0;
    logic chk_en = 1'b0;

    // Link model: rules of the protocol, one step per clock edge.
    int          m_st = S_WAIT, m_match = 0, m_to = 0, m_age = 0, m_wcnt = 0;
    logic [15:0] m_tot = 0;
    logic        m_mis = 0, m_rdy = 0, m_hc = 0, m_rxv = 0;
    logic [31:0] m_tx = IDLE_LIT, m_rxd = 0;
    logic [3:0]  m_txk = 4'b0001;

    always @(posedge clk) begin : model
        int ns;
        logic ok, good, wbad, w_hs, w_hsv, w_ack, w_dat, trip, acc;
        logic [31:0] d;
        logic [3:0] k;
        if (rst) begin
            m_st = S_WAIT; m_match = 0; m_to = 0; m_age = 0; m_wcnt = 0; m_tot = 0;
            m_mis = 0; m_rdy = 0; m_hc = 0; m_rxv = 0; m_tx = IDLE_LIT; m_txk = 4'b0001; m_rxd = 0;
        end else begin
            d = lnk_if.gt_rx_data_in;
            k = lnk_if.gt_rx_charisk_in;
            ok = txdn && rxdn;
            good = (lnk_if.gt_rx_disperr_in == 0) && (lnk_if.gt_rx_encerr_in == 0);
            wbad = !good;
            w_hs = good && k == 4'b0001 && d == HS_LIT;
            w_ack = good && k == 4'b0001 && d == ACK_LIT;
            w_hsv = good && k == 4'b0001 && d[31:16] == 16'h4853 && d[7:0] == 8'hBC && d[15:8] != 8'h01;
            w_dat = good && k == 4'b0000;
            trip = 0;
            if (m_st == S_WAIT) begin
                m_age = 0; m_wcnt = 0;
            end else begin
                if (m_age % WIN_N == 0) m_wcnt = 0;
                if (wbad) begin
                    m_wcnt++;
                    if (m_tot != 16'hFFFF) m_tot++;
                end
                if (wbad && m_wcnt == LIM_N) begin trip = 1; m_wcnt = 0; end
                m_age++;
            end
            ns = m_st;
            if (!ok) ns = S_WAIT;
            else case (m_st)
                S_WAIT: ns = S_HS;
                S_HS: if (w_hs) begin
                          m_match++;
                          if (m_match == HS_N) ns = S_ACK;
                      end else begin
                          if (w_hsv) m_mis = 1;
                          m_match = 0;
                      end
                S_ACK: if (w_ack || w_dat) ns = S_LINK;
                       else begin m_to++; if (m_to == TO_N) ns = S_HS; end
                default: if (w_hs || trip) ns = S_HS;
            endcase
            if (ns != S_HS) m_match = 0;
            if (ns != S_ACK) m_to = 0;
            acc = lnk_if.usr_tx_vld_in && m_rdy;
            if (acc) begin m_tx = lnk_if.usr_tx_data_in; m_txk = 4'b0000; end
            else begin
                m_txk = 4'b0001;
                m_tx = (ns == S_HS) ? HS_LIT : (ns == S_ACK) ? ACK_LIT : IDLE_LIT;
            end
            m_rxv = (m_st == S_LINK) && (ns == S_LINK) && w_dat;
            if (m_rxv) m_rxd = d;
            m_rdy = (ns == S_LINK);
            m_hc = m_rdy;
            m_st = ns;
        end
    end

    always @(negedge clk) begin : compare
        logic [87:0] got, exp;
        if (chk_en) begin
            got = {lnk_if.gt_tx_data_out, lnk_if.gt_tx_charisk_out, lnk_if.usr_tx_rdy_out,
                   lnk_if.usr_rx_data_out, lnk_if.usr_rx_vld_out, hc, mis, ec};
            exp = {m_tx, m_txk, m_rdy, m_rxd, m_rxv, m_hc, m_mis, m_tot};
            n_total++;
            if (got !== exp) begin
                n_bad++;
                if (n_print < 10) $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
                n_print++;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rxw(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de, input logic [3:0] ee);
        lnk_if.gt_rx_data_in = d;
        lnk_if.gt_rx_charisk_in = k;
        lnk_if.gt_rx_disperr_in = de;
        lnk_if.gt_rx_encerr_in = ee;
    endtask

    task automatic link_up();
        int n;
        n = 0;
        rxw(HS_LIT, 4'b0001, 4'b0, 4'b0);
        while (lnk_if.gt_tx_data_out !== ACK_LIT && n < 200) begin step(); n++; end
        chk("reach_send_ack", 64'(n < 200), 64'd1);
        rxw(ACK_LIT, 4'b0001, 4'b0, 4'b0);
        n = 0;
        while (hc !== 1'b1 && n < 20) begin step(); n++; end
        chk("reach_linked", 64'(n < 20), 64'd1);
        rxw(IDLE_LIT, 4'b0001, 4'b0, 4'b0);
    endtask

    initial begin : stim
        int n, r, prof, len, vcnt;
        logic [31:0] d;
        logic [3:0] k, de, ee;
        rst = 1; txdn = 1; rxdn = 1; lb_rst = 1;
        rxw(IDLE_LIT, 4'b0001, 4'b0, 4'b0);
        lnk_if.usr_tx_data_in = 0; lnk_if.usr_tx_vld_in = 0;
        repeat (2) @(posedge clk);
        step();
        chk_en = 1;
        chk("rst_tx_data", 64'(lnk_if.gt_tx_data_out), 64'(IDLE_LIT));
        chk("rst_tx_k", 64'(lnk_if.gt_tx_charisk_out), 64'd1);
        chk("rst_flags", 64'({hc, mis, lnk_if.usr_tx_rdy_out, lnk_if.usr_rx_vld_out}), 64'd0);
        chk("rst_err_cnt", 64'(ec), 64'd0);
        chk("rst_rx_data", 64'(lnk_if.usr_rx_data_out), 64'd0);

        lb_rst = 0;
        step();
        chk("lb_send_hs", 64'(lb_a.gt_tx_data_out), 64'(HS_LIT));
        n = 0;
        while (!(lb_hc_a === 1'b1 && lb_hc_b === 1'b1) && n < 100) begin step(); n++; end
        chk("lb_link_min", 64'(n >= HS_N), 64'd1);
        chk("lb_link_max", 64'(n <= HS_N + 4), 64'd1);

        rst = 0;
        rxw(HS_BADV, 4'b0001, 4'b0, 4'b0);
        repeat (6) step();
        chk("ver_mismatch", 64'(mis), 64'd1);
        chk("stay_send_hs", 64'(lnk_if.gt_tx_data_out), 64'(HS_LIT));

        rxw(HS_LIT, 4'b0001, 4'b0, 4'b0);
        n = 0;
        while (lnk_if.gt_tx_data_out !== ACK_LIT && n < 100) begin step(); n++; end
        chk("hs_match_cycles", 64'(n), 64'(HS_N));
        n = 0;
        while (lnk_if.gt_tx_data_out === ACK_LIT && n < 2000) begin step(); n++; end
        chk("ack_timeout_cycles", 64'(n), 64'(TO_N));
        chk("timeout_tx_hs", 64'(lnk_if.gt_tx_data_out), 64'(HS_LIT));

        link_up();
        chk("linked_hc", 64'(hc), 64'd1);
        chk("linked_rdy", 64'(lnk_if.usr_tx_rdy_out), 64'd1);

        lnk_if.usr_tx_data_in = 32'hDEAD_BEEF; lnk_if.usr_tx_vld_in = 1;
        step();
        lnk_if.usr_tx_vld_in = 0; lnk_if.usr_tx_data_in = 0;
        chk("tx_user_word", 64'(lnk_if.gt_tx_data_out), 64'h0000_0000_DEAD_BEEF);
        chk("tx_user_k", 64'(lnk_if.gt_tx_charisk_out), 64'd0);
        step();
        chk("tx_idle_after", 64'(lnk_if.gt_tx_data_out), 64'(IDLE_LIT));

        rxw(32'h1234_5678, 4'b0000, 4'b0, 4'b0);
        step();
        rxw(IDLE_LIT, 4'b0001, 4'b0, 4'b0);
        chk("rx_vld", 64'(lnk_if.usr_rx_vld_out), 64'd1);
        chk("rx_data", 64'(lnk_if.usr_rx_data_out), 64'h1234_5678);
        step();
        chk("rx_vld_drop", 64'(lnk_if.usr_rx_vld_out), 64'd0);
        chk("rx_data_hold", 64'(lnk_if.usr_rx_data_out), 64'h1234_5678);

        n = 0;
        while ((m_age % WIN_N) > 200 && n < 300) begin step(); n++; end
        for (int i = 0; i < LIM_N; i++) begin
            rxw($urandom, 4'b0000, 4'b0, 4'b0001);
            step();
        end
        rxw(IDLE_LIT, 4'b0001, 4'b0, 4'b0);
        chk("err_trip_hc", 64'(hc), 64'd0);
        chk("err_cnt", 64'(ec), 64'd8);
        chk("err_trip_tx", 64'(lnk_if.gt_tx_data_out), 64'(HS_LIT));

        link_up();
        rxw(32'hA5A5_0001, 4'b0000, 4'b0, 4'b0);
        step();
        rxdn = 0;
        step();
        chk("drop_tx_idle", 64'(lnk_if.gt_tx_data_out), 64'(IDLE_LIT));
        chk("drop_hc", 64'(hc), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            vcnt += int'(lnk_if.usr_rx_vld_out);
            step();
        end
        chk("drop_no_rx_vld", 64'(vcnt), 64'd0);
        rxdn = 1;

        for (int p = 0; p < 40; p++) begin
            prof = p % 4;
            len = $urandom_range(20, 300);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 99);
                d = $urandom; k = 4'b0000; de = 0; ee = 0;
                case (prof)
                    0: if (r < 88) begin d = HS_LIT; k = 4'b0001; end
                       else if (r < 92) begin d = HS_BADV; k = 4'b0001; end
                       else k = 4'($urandom_range(0, 15));
                    1: if (r < 50) begin d = ACK_LIT; k = 4'b0001; end
                       else if (r >= 90) begin d = IDLE_LIT; k = 4'b0001; end
                    2: if (r >= 90) begin d = IDLE_LIT; k = 4'b0001; end
                       else if (r >= 85) begin d = HS_LIT; k = 4'b0001; end
                    default: case (r % 6)
                        0: begin d = HS_LIT; k = 4'b0001; end
                        1: begin d = HS_BADV; k = 4'b0001; end
                        2: begin d = ACK_LIT; k = 4'b0001; end
                        3: begin d = IDLE_LIT; k = 4'b0001; end
                        4: k = 4'b0000;
                        default: k = 4'($urandom_range(0, 15));
                    endcase
                endcase
                if ((prof == 2 && $urandom_range(0, 99) < 3) || (prof == 3 && $urandom_range(0, 99) < 15)) begin
                    if ($urandom_range(0, 1) == 1) de = 4'($urandom_range(1, 15));
                    else ee = 4'($urandom_range(1, 15));
                end
                rxw(d, k, de, ee);
                lnk_if.usr_tx_vld_in = 1'($urandom_range(0, 1));
                lnk_if.usr_tx_data_in = $urandom;
                rst = ($urandom_range(0, 999) == 0);
                txdn = ($urandom_range(0, 399) != 0);
                rxdn = ($urandom_range(0, 399) != 0);
                step();
            end
        end
        rst = 0; txdn = 1; rxdn = 1;
        step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
